line_mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single line-wide data memory port: the 128-bit read/write bus with separate read/write addresses and one write enable.
- Sits between two line-fill/write-back clients (instruction-cache and data-cache refill engines) and data_ram.
- Grants one whole-line transaction at a time, round-robin.
- Drives the memory address/WE/write-data, waits the memory latency, captures the read line, and acknowledges the winner.

---
 rtl/line_mem_arbiter_if.sv | 46 ++++
 rtl/line_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_line_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the line memory arbiter.
// The slave modport is the arbiter view. The master modport is the environment view:
// both requesters plus data_ram.
interface line_mem_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_WIDTH    = 128
);
  logic                     rq0_req;
  logic                     rq0_we;
  logic [ADDRESS_WIDTH-1:0] rq0_addr;
  logic [LINE_WIDTH-1:0]    rq0_wdata;
  logic                     rq0_ack;

  logic                     rq1_req;
  logic                     rq1_we;
  logic [ADDRESS_WIDTH-1:0] rq1_addr;
  logic [LINE_WIDTH-1:0]    rq1_wdata;
  logic                     rq1_ack;

  logic [LINE_WIDTH-1:0]    rd_line;
  logic [ADDRESS_WIDTH-1:0] mem_read_addr;
  logic [ADDRESS_WIDTH-1:0] mem_write_addr;
  logic [LINE_WIDTH-1:0]    mem_wdata;
  logic                     mem_we;
  logic [LINE_WIDTH-1:0]    mem_rdata;
  logic                     busy;
  logic                     grant_id;

  modport slave (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  mem_rdata,
    output rq0_ack, rq1_ack, rd_line,
    output mem_read_addr, mem_write_addr, mem_wdata, mem_we,
    output busy, grant_id
  );

  modport master (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output mem_rdata,
    input  rq0_ack, rq1_ack, rd_line,
    input  mem_read_addr, mem_write_addr, mem_wdata, mem_we,
    input  busy, grant_id
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// Round-robin arbiter and sequencer for the line-wide data memory port.
// It serves two refill clients, one whole-line read or write at a time.
module line_mem_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned LINE_WIDTH    = 128,
  parameter int unsigned MEM_LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  line_mem_arbiter_if.slave bus
);

  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK =
    {{(ADDRESS_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                   state_q;
  logic                     we_q;
  logic [3:0]               cnt_q;
  logic                     last_grant_q;
  logic                     grant_id_q;
  logic                     busy_q;
  logic                     ack0_q;
  logic                     ack1_q;
  logic                     mem_we_q;
  logic [ADDRESS_WIDTH-1:0] mem_raddr_q;
  logic [ADDRESS_WIDTH-1:0] mem_waddr_q;
  logic [LINE_WIDTH-1:0]    mem_wdata_q;
  logic [LINE_WIDTH-1:0]    rd_line_q;

  logic                     grant_valid_d;
  logic                     grant_sel_d;
  logic                     req_we_d;
  logic [ADDRESS_WIDTH-1:0] req_addr_d;
  logic [LINE_WIDTH-1:0]    req_wdata_d;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant_valid_d = bus.rq0_req | bus.rq1_req;
    grant_sel_d   = (bus.rq0_req && bus.rq1_req) ? ~last_grant_q : ~bus.rq0_req;
    req_we_d      = grant_sel_d ? bus.rq1_we    : bus.rq0_we;
    req_addr_d    = (grant_sel_d ? bus.rq1_addr : bus.rq0_addr) & ALIGN_MASK;
    req_wdata_d   = grant_sel_d ? bus.rq1_wdata : bus.rq0_wdata;
  end

  // Transaction sequencer with registered outputs
  // The request is latched straight into the memory-side output registers at grant.
  // That puts address/WE on the bus for the whole ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_raddr_q  <= '0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      rd_line_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_valid_d) begin
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            grant_id_q <= grant_sel_d;
            we_q       <= req_we_d;
            if (req_we_d) begin
              mem_we_q    <= 1'b1;
              mem_waddr_q <= req_addr_d;
              mem_wdata_q <= req_wdata_d;
            end else begin
              mem_raddr_q <= req_addr_d;
            end
          end
        end
        ISSUE: begin
          if (we_q) begin
            state_q <= DONE;
            ack0_q  <= ~grant_id_q;
            ack1_q  <= grant_id_q;
          end else begin
            cnt_q   <= CNT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rd_line_q <= bus.mem_rdata;
            state_q   <= DONE;
            ack0_q    <= ~grant_id_q;
            ack1_q    <= grant_id_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          last_grant_q <= grant_id_q;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rq0_ack        = ack0_q;
  assign bus.rq1_ack        = ack1_q;
  assign bus.rd_line        = rd_line_q;
  assign bus.mem_read_addr  = mem_raddr_q;
  assign bus.mem_write_addr = mem_waddr_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.busy           = busy_q;
  assign bus.grant_id       = grant_id_q;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Bench for line_mem_arbiter: directed scenarios, then randomized traffic checked
// against a transaction-level model. Extra instances exercise extreme latencies.
module tb_line_mem_arbiter;

  localparam int LAT = 2;
  localparam logic [127:0] A5 = {16{8'hA5}};
  localparam logic [127:0] K  = {4{32'h3C3C_0F0F}};

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  line_mem_arbiter_if #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128)) b2 ();
  line_mem_arbiter_if #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128)) b1 ();
  line_mem_arbiter_if #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128)) b15 ();

  line_mem_arbiter #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128), .MEM_LATENCY(LAT))
    dut (.clk(clk), .rst_n(rst_n), .bus(b2));
  line_mem_arbiter #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128), .MEM_LATENCY(1))
    dut_l1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  line_mem_arbiter #(.ADDRESS_WIDTH(32), .LINE_WIDTH(128), .MEM_LATENCY(15))
    dut_l15 (.clk(clk), .rst_n(rst_n), .bus(b15));

  function automatic logic [127:0] pat(input logic [7:0] idx);
    return {4{24'hC0FFEE, idx}};
  endfunction

  // data_ram stand-in: 256 lines indexed by addr[11:4], optional per-cycle salt
  logic [127:0] ram [256];
  bit           wr  [256];
  logic [7:0]   ridx;
  bit           force_en = 1'b0;
  bit           salt_en  = 1'b0;
  logic [127:0] force_rdata = '0;

  assign ridx = b2.mem_read_addr[11:4];
  assign b2.mem_rdata = force_en ? force_rdata :
                        ((wr[ridx] ? ram[ridx] : pat(ridx)) ^ (salt_en ? {4{cyc}} : 128'd0));
  assign b1.mem_rdata  = {4{cyc}} ^ K;
  assign b15.mem_rdata = {4{cyc}} ^ K;

  always @(posedge clk) begin
    if (b2.mem_we) begin
      ram[b2.mem_write_addr[11:4]] <= b2.mem_wdata;
      wr[b2.mem_write_addr[11:4]]  <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference model state
  logic [127:0] mm [256];
  int           g_c, a_c;
  bit           g_who, g_we, lg;
  logic [31:0]  g_addr, m_raddr, m_waddr;
  logic [127:0] g_wdata, g_rd, m_wdata, m_rdline;
  bit           r_req [2];
  bit           r_we  [2];
  logic [31:0]  r_addr [2];
  logic [127:0] r_wdata [2];
  int           r_cool [2];

  task automatic drive_rq();
    b2.rq0_req = r_req[0]; b2.rq0_we = r_we[0]; b2.rq0_addr = r_addr[0]; b2.rq0_wdata = r_wdata[0];
    b2.rq1_req = r_req[1]; b2.rq1_we = r_we[1]; b2.rq1_addr = r_addr[1]; b2.rq1_wdata = r_wdata[1];
  endtask

  task automatic model_reset();
    g_c = -10; a_c = -10; g_who = 1'b0; g_we = 1'b0; lg = 1'b1;
    g_addr = '0; g_wdata = '0; g_rd = '0;
    m_raddr = '0; m_waddr = '0; m_wdata = '0; m_rdline = '0;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = '0; r_wdata[i] = '0; r_cool[i] = 0;
    end
    drive_rq();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One model step per cycle: predict outputs, compare, then arbitrate
  task automatic run_model(input int ncyc, input int p_req, input bit rd_only, input bit cont);
    int c;
    int who;
    int prev_ack;
    bit prev_who;
    bit seen;
    seen = 1'b0; prev_ack = 0; prev_who = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      c = cyc;
      if (c == g_c + 1) begin
        if (g_we) begin m_waddr = g_addr; m_wdata = g_wdata; end
        else m_raddr = g_addr;
      end
      if (c == a_c && !g_we) m_rdline = g_rd;
      chk("ack0", b2.rq0_ack, (c == a_c && !g_who));
      chk("ack1", b2.rq1_ack, (c == a_c && g_who));
      chk("busy", b2.busy, (c > g_c && c <= a_c));
      chk("mem_we", b2.mem_we, (c == g_c + 1 && g_we));
      chk("mem_read_addr", b2.mem_read_addr, m_raddr);
      chk("mem_write_addr", b2.mem_write_addr, m_waddr);
      chk("mem_wdata", b2.mem_wdata, m_wdata);
      chk("rd_line", b2.rd_line, m_rdline);
      if (c > g_c && c <= a_c) chk("grant_id", b2.grant_id, g_who);
      if (cont && (b2.rq0_ack || b2.rq1_ack)) begin
        if (!seen) chk("cont_first", b2.rq1_ack, 1'b0);
        else begin
          chk("cont_alt", b2.rq1_ack, !prev_who);
          chk("cont_gap", c - prev_ack, 5);
        end
        seen = 1'b1; prev_who = b2.rq1_ack; prev_ack = c;
      end
      if (c == a_c) begin
        r_req[g_who] = 1'b0; r_cool[g_who] = c + 2; lg = g_who;
      end
      for (int i = 0; i < 2; i++) begin
        if (!r_req[i] && c >= r_cool[i] && $urandom_range(99) < p_req) begin
          r_req[i]   = 1'b1;
          r_we[i]    = rd_only ? 1'b0 : 1'($urandom_range(1));
          r_addr[i]  = ($urandom_range(255) << 4) | $urandom_range(15);
          r_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (c > a_c && (r_req[0] || r_req[1])) begin
        who     = (r_req[0] && r_req[1]) ? int'(!lg) : (r_req[0] ? 0 : 1);
        g_c     = c;
        g_who   = 1'(who);
        g_we    = r_we[who];
        g_addr  = r_addr[who] & ~32'hF;
        g_wdata = r_wdata[who];
        a_c     = c + (g_we ? 2 : 2 + LAT);
        if (g_we) mm[g_addr[11:4]] = g_wdata;
        else g_rd = mm[g_addr[11:4]] ^ {4{32'(a_c - 1)}};
      end
      drive_rq();
    end
  endtask

  initial begin
    int n0;
    logic [127:0] wd;
    wd = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    for (int i = 0; i < 256; i++) mm[i] = pat(8'(i));
    b1.rq0_req = 0; b1.rq0_we = 0; b1.rq0_addr = '0; b1.rq0_wdata = '0;
    b1.rq1_req = 0; b1.rq1_we = 0; b1.rq1_addr = '0; b1.rq1_wdata = '0;
    b15.rq0_req = 0; b15.rq0_we = 0; b15.rq0_addr = '0; b15.rq0_wdata = '0;
    b15.rq1_req = 0; b15.rq1_we = 0; b15.rq1_addr = '0; b15.rq1_wdata = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ack0", b2.rq0_ack, 0);
    chk("rst_ack1", b2.rq1_ack, 0);
    chk("rst_mem_we", b2.mem_we, 0);
    chk("rst_busy", b2.busy, 0);
    chk("rst_grant_id", b2.grant_id, 0);
    chk("rst_raddr", b2.mem_read_addr, 0);
    chk("rst_waddr", b2.mem_write_addr, 0);
    chk("rst_wdata", b2.mem_wdata, 0);
    chk("rst_rd_line", b2.rd_line, 0);
    rst_n = 1'b1;

    // Directed read by requester 0
    @(negedge clk);
    force_en = 1'b1; force_rdata = A5;
    b2.rq0_req = 1; b2.rq0_we = 0; b2.rq0_addr = 32'h0000_1234;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("rd_raddr", b2.mem_read_addr, 32'h0000_1230);
      chk("rd_ack0", b2.rq0_ack, (k == 4));
      chk("rd_ack1", b2.rq1_ack, 0);
      chk("rd_busy", b2.busy, (k <= 4));
      chk("rd_mem_we", b2.mem_we, 0);
      if (k >= 4) chk("rd_line", b2.rd_line, A5);
      if (k == 4) b2.rq0_req = 0;
    end

    // Directed write by requester 1
    b2.rq1_req = 1; b2.rq1_we = 1; b2.rq1_addr = 32'h0000_0040; b2.rq1_wdata = wd;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("wr_mem_we", b2.mem_we, (k == 1));
      if (k == 1) begin
        chk("wr_waddr", b2.mem_write_addr, 32'h0000_0040);
        chk("wr_wdata", b2.mem_wdata, wd);
        chk("wr_grant_id", b2.grant_id, 1);
      end
      chk("wr_ack1", b2.rq1_ack, (k == 2));
      chk("wr_ack0", b2.rq0_ack, 0);
      chk("wr_rd_line", b2.rd_line, A5);
      if (k == 2) b2.rq1_req = 0;
    end
    mm[8'h04] = wd;
    force_en = 1'b0;

    // Reset in the second WAIT cycle, then a fresh read
    @(negedge clk);
    b2.rq0_req = 1; b2.rq0_we = 0; b2.rq0_addr = 32'h0000_0200;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", b2.busy, 0);
    chk("mrst_mem_we", b2.mem_we, 0);
    chk("mrst_ack0", b2.rq0_ack, 0);
    chk("mrst_raddr", b2.mem_read_addr, 0);
    @(negedge clk);
    chk("mrst_ack0_hold", b2.rq0_ack, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("rerd_ack0", b2.rq0_ack, (k == 4));
      chk("rerd_busy", b2.busy, (k <= 4));
      chk("rerd_raddr", b2.mem_read_addr, 32'h0000_0200);
      if (k == 4) b2.rq0_req = 0;
    end

    // Requester 1 pulses a request while requester 0 is served
    b2.rq0_req = 1; b2.rq0_we = 0; b2.rq0_addr = 32'h0000_0300;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("wd_ack1", b2.rq1_ack, 0);
      chk("wd_ack0", b2.rq0_ack, (k == 4));
      chk("wd_busy", b2.busy, (k <= 4));
      if (k <= 4) chk("wd_grant_id", b2.grant_id, 0);
      if (k == 2) begin b2.rq1_req = 1; b2.rq1_we = 1; b2.rq1_addr = 32'h0000_0500; end
      if (k == 3) b2.rq1_req = 0;
      if (k == 4) b2.rq0_req = 0;
    end

    // Continuous contention, then random mixed traffic
    salt_en = 1'b1;
    apply_reset();
    run_model(60, 100, 1'b1, 1'b1);
    run_model(1500, 40, 1'b0, 1'b0);

    // Latency extremes on the MEM_LATENCY=1 and =15 instances
    @(negedge clk);
    n0 = cyc;
    b1.rq0_req = 1; b1.rq0_addr = 32'h0000_0050;
    b15.rq0_req = 1; b15.rq0_addr = 32'h0000_0050;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      chk("l1_ack", b1.rq0_ack, (k == 3));
      chk("l15_ack", b15.rq0_ack, (k == 17));
      if (k == 3) begin
        chk("l1_rd_line", b1.rd_line, {4{32'(n0 + k - 1)}} ^ K);
        b1.rq0_req = 0;
      end
      if (k == 17) begin
        chk("l15_rd_line", b15.rd_line, {4{32'(n0 + k - 1)}} ^ K);
        b15.rq0_req = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
